// File: rtl/bcd_counter_multi.sv
// Multi-digit packed-BCD up/down counter with load, enable and cascade carry.
// It wraps or saturates at the terminal count and flags invalid load digits.

module bcd_digit (
  input  logic [3:0] cur,
  input  logic       up,
  input  logic       step,
  output logic [3:0] nxt
);
  always_comb begin
    nxt = cur;
    if (step) begin
      if (up) nxt = (cur == 4'd9) ? 4'd0 : cur + 4'd1;
      else    nxt = (cur == 4'd0) ? 4'd9 : cur - 4'd1;
    end
  end
endmodule

module bcd_counter_multi #(
  parameter int                  DIGITS    = 4,
  parameter bit                  SATURATE  = 1'b0,
  parameter logic [4*DIGITS-1:0] RESET_VAL = '0
) (
  input  logic                CLK,
  input  logic                CLR,
  input  logic                ENABLE,
  input  logic                LOAD,
  input  logic                UP,
  input  logic                CI,
  input  logic [4*DIGITS-1:0] D,
  output logic [4*DIGITS-1:0] Q,
  output logic                CO,
  output logic                WRAP,
  output logic                LOAD_ERR
);
  logic [DIGITS-1:0][3:0] q_r, q_nxt, d_fix;
  logic [DIGITS-1:0]      term, bad;
  logic [DIGITS:0]        ripple;
  logic                   count_en, at_term;

  // ripple[k]: every digit below k sits at its terminal value (9 up, 0 down)
  always_comb begin
    ripple[0] = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      term[k]     = UP ? (q_r[k] == 4'd9) : (q_r[k] == 4'd0);
      ripple[k+1] = ripple[k] & term[k];
      bad[k]      = D[4*k +: 4] > 4'd9;
      d_fix[k]    = bad[k] ? 4'd0 : D[4*k +: 4];
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .cur (q_r[g]),
      .up  (UP),
      .step(ripple[g]),
      .nxt (q_nxt[g])
    );
  end

  assign count_en = ENABLE & ~LOAD & CI;
  assign at_term  = ripple[DIGITS];
  assign CO       = count_en & at_term;
  assign Q        = q_r;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      q_r      <= RESET_VAL;
      WRAP     <= 1'b0;
      LOAD_ERR <= 1'b0;
    end else begin
      WRAP <= 1'b0;
      if (ENABLE && LOAD) begin
        q_r <= d_fix;
        if (|bad) LOAD_ERR <= 1'b1;
      end else if (count_en && !(SATURATE && at_term)) begin
        q_r  <= q_nxt;
        WRAP <= at_term;
      end
    end
  end
endmodule

// File: tb/tb_bcd_counter_multi.sv
// Directed vector table for the counter, a saturate sequence, and a cascade
// check of two 2-digit instances against a 4-digit instance and an integer model.

module tb_bcd_counter_multi;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr, en, ld, up, ci;
  logic [15:0] d;
  logic [15:0] q0, q1;
  logic        co0, co1, wr0, wr1, er0, er1;

  bcd_counter_multi #(.DIGITS(4), .SATURATE(1'b0), .RESET_VAL(16'h0000)) u_wrap (
    .CLK(clk), .CLR(clr), .ENABLE(en), .LOAD(ld), .UP(up), .CI(ci), .D(d),
    .Q(q0), .CO(co0), .WRAP(wr0), .LOAD_ERR(er0));

  bcd_counter_multi #(.DIGITS(4), .SATURATE(1'b1), .RESET_VAL(16'h0000)) u_sat (
    .CLK(clk), .CLR(clr), .ENABLE(en), .LOAD(ld), .UP(up), .CI(ci), .D(d),
    .Q(q1), .CO(co1), .WRAP(wr1), .LOAD_ERR(er1));

  // cascade pair and 4-digit reference
  logic        c_clr, c_en, c_ld, c_up;
  logic [15:0] c_d;
  logic [7:0]  cq_lo, cq_hi;
  logic [15:0] rq;
  logic        co_lo, co_hi, rco, cw_lo, cw_hi, ce_lo, ce_hi, rw, re;

  bcd_counter_multi #(.DIGITS(2), .SATURATE(1'b0), .RESET_VAL(8'h00)) u_lo (
    .CLK(clk), .CLR(c_clr), .ENABLE(c_en), .LOAD(c_ld), .UP(c_up), .CI(1'b1), .D(c_d[7:0]),
    .Q(cq_lo), .CO(co_lo), .WRAP(cw_lo), .LOAD_ERR(ce_lo));

  bcd_counter_multi #(.DIGITS(2), .SATURATE(1'b0), .RESET_VAL(8'h00)) u_hi (
    .CLK(clk), .CLR(c_clr), .ENABLE(c_en), .LOAD(c_ld), .UP(c_up), .CI(co_lo), .D(c_d[15:8]),
    .Q(cq_hi), .CO(co_hi), .WRAP(cw_hi), .LOAD_ERR(ce_hi));

  bcd_counter_multi #(.DIGITS(4), .SATURATE(1'b0), .RESET_VAL(16'h0000)) u_ref (
    .CLK(clk), .CLR(c_clr), .ENABLE(c_en), .LOAD(c_ld), .UP(c_up), .CI(1'b1), .D(c_d),
    .Q(rq), .CO(rco), .WRAP(rw), .LOAD_ERR(re));

  typedef struct {
    logic        clr, en, ld, up, ci;
    logic [15:0] d;
    logic        co;
    logic [15:0] q;
    logic        wrap, err;
  } vec_t;

  vec_t vecs[$];
  int   errs = 0;
  int   checks = 0;

  function automatic vec_t mk(input logic c, e, l, u, i, input logic [15:0] dd,
                              input logic co, input logic [15:0] q, input logic w, er);
    vec_t v;
    v.clr = c; v.en = e; v.ld = l; v.up = u; v.ci = i; v.d = dd;
    v.co = co; v.q = q; v.wrap = w; v.err = er;
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic c, e, l, u, i, input logic [15:0] dd);
    clr = c; en = e; ld = l; up = u; ci = i; d = dd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int m;

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
    c_clr = 1'b1; c_en = 1'b0; c_ld = 1'b0; c_up = 1'b1; c_d = 16'h0000;
    @(negedge clk);

    // clr en ld up ci  d  |  co  q  wrap err
    vecs.push_back(mk(1,0,0,1,1,16'h0000, 0,16'h0000,0,0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0,0,0,1,1,16'h0000, 0,16'h0000,0,0));
    vecs.push_back(mk(0,1,1,1,1,16'h0998, 0,16'h0998,0,0));
    vecs.push_back(mk(0,1,0,1,1,16'h0000, 0,16'h0999,0,0));
    vecs.push_back(mk(0,1,0,1,1,16'h0000, 0,16'h1000,0,0));
    vecs.push_back(mk(0,1,1,1,1,16'h9999, 0,16'h9999,0,0));
    vecs.push_back(mk(0,1,0,1,0,16'h0000, 0,16'h9999,0,0));
    vecs.push_back(mk(0,1,0,1,1,16'h0000, 1,16'h0000,1,0));
    vecs.push_back(mk(0,0,0,1,1,16'h0000, 0,16'h0000,0,0));
    vecs.push_back(mk(0,1,1,0,1,16'h1000, 0,16'h1000,0,0));
    vecs.push_back(mk(0,1,0,0,1,16'h0000, 0,16'h0999,0,0));
    vecs.push_back(mk(0,1,0,0,1,16'h0000, 0,16'h0998,0,0));
    vecs.push_back(mk(0,1,1,0,1,16'h0000, 0,16'h0000,0,0));
    vecs.push_back(mk(0,1,0,0,1,16'h0000, 1,16'h9999,1,0));
    vecs.push_back(mk(0,1,1,1,1,16'h9999, 0,16'h9999,0,0));
    vecs.push_back(mk(0,0,1,1,1,16'h1234, 0,16'h9999,0,0));
    vecs.push_back(mk(1,1,1,1,1,16'h5555, 0,16'h0000,0,0));
    vecs.push_back(mk(0,1,1,1,1,16'h12B4, 0,16'h1204,0,1));
    for (int i = 0; i < 10; i++) vecs.push_back(mk(0,1,0,1,1,16'h0000, 0,to_bcd(1205+i),0,1));
    vecs.push_back(mk(0,1,0,0,1,16'h0000, 0,16'h1213,0,1));
    vecs.push_back(mk(1,0,0,1,1,16'h0000, 0,16'h0000,0,0));

    foreach (vecs[i]) begin
      drive(vecs[i].clr, vecs[i].en, vecs[i].ld, vecs[i].up, vecs[i].ci, vecs[i].d);
      #1;
      chk($sformatf("v%0d co", i), 16'(co0), 16'(vecs[i].co));
      tick();
      chk($sformatf("v%0d q", i), q0, vecs[i].q);
      chk($sformatf("v%0d wrap", i), 16'(wr0), 16'(vecs[i].wrap));
      chk($sformatf("v%0d load_err", i), 16'(er0), 16'(vecs[i].err));
    end

    // saturating instance: borrow, then hold at both terminals
    drive(0,1,1,0,1,16'h1000); tick(); chk("sat load", q1, 16'h1000);
    drive(0,1,0,0,1,16'h0000); tick(); chk("sat borrow", q1, 16'h0999);
    drive(0,1,1,0,1,16'h0000); tick(); chk("sat load0", q1, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      drive(0,1,0,0,1,16'h0000);
      #1 chk($sformatf("sat co dn%0d", i), 16'(co1), 16'h1);
      tick();
      chk($sformatf("sat q dn%0d", i), q1, 16'h0000);
      chk($sformatf("sat wrap dn%0d", i), 16'(wr1), 16'h0);
    end
    drive(0,1,1,1,1,16'h9999); tick();
    drive(0,1,0,1,1,16'h0000);
    #1 chk("sat co up", 16'(co1), 16'h1);
    tick();
    chk("sat q up", q1, 16'h9999);
    chk("sat wrap up", 16'(wr1), 16'h0);

    // cascade: 0099 -> 0100, then random enable/direction
    tick();
    c_clr = 1'b0; c_en = 1'b1; c_ld = 1'b1; c_d = 16'h0099; tick();
    c_ld = 1'b0; c_up = 1'b1; tick();
    chk("casc 0100", {cq_hi, cq_lo}, 16'h0100);
    chk("ref 0100", rq, 16'h0100);
    c_ld = 1'b1; c_d = 16'h9950; tick();
    c_ld = 1'b0;
    m = 9950;
    for (int n = 0; n < 10000; n++) begin
      c_en = 1'($urandom_range(0, 1));
      // up-biased first half, down-biased second half so both wraps occur
      c_up = (n < 5000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      #1;
      chk($sformatf("casc co n%0d", n), 16'(co_hi), 16'(c_en && (c_up ? (m == 9999) : (m == 0))));
      tick();
      if (c_en) m = c_up ? (m + 1) % 10000 : (m + 9999) % 10000;
      chk($sformatf("casc q n%0d", n), {cq_hi, cq_lo}, to_bcd(m));
      chk($sformatf("ref q n%0d", n), rq, to_bcd(m));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
